// File: rtl/multimode_bram_port_arbiter.sv
// multimode_bram_port_arbiter
// Selects one of NUM_MODES requester bundles and drives a banked BRAM array
// through one register stage. Mode changes use a request/ack handshake.
// While a change is in progress, the arbiter first drains in-flight reads and
// then switches, so no outstanding read is lost.
//
// Optional build macro: MODE_VIOLATION_CNT_EN
//   When defined, the arbiter adds output viol_cnt[15:0]. It is a saturating
//   count of cycles in which a non-owning mode drives any we/re bit. During
//   DRAIN/SWITCH, every mode counts as non-owning.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ACTIVE | cur_mode bundle forwarded; mode requests accepted
// DRAIN  | we/re gated off; wait READ_LATENCY cycles and for rd_valid == 0
// SWITCH | cur_mode takes the latched id; ack is issued on return to ACTIVE
module multimode_bram_port_arbiter #(
    parameter int DW           = 16,
    parameter int NUM_BRAMS    = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int NUM_MODES    = 2,
    parameter int READ_LATENCY = 1,
    parameter int RESET_MODE   = 0,
    localparam int MODE_W      = $clog2(NUM_MODES)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     mode_req_valid,
    input  logic [MODE_W-1:0]                        mode_req_id,
    output logic                                     mode_req_ready,
    output logic                                     mode_ack,
    output logic                                     mode_err,
    output logic [MODE_W-1:0]                        cur_mode,
    output logic                                     mode_busy,
    input  logic [NUM_MODES*NUM_BRAMS-1:0]           m_we_flat,
    input  logic [NUM_MODES*NUM_BRAMS*ADDR_WIDTH-1:0] m_waddr_flat,
    input  logic [NUM_MODES*NUM_BRAMS*DW-1:0]        m_din_flat,
    input  logic [NUM_MODES*NUM_BRAMS-1:0]           m_re_flat,
    input  logic [NUM_MODES*NUM_BRAMS*ADDR_WIDTH-1:0] m_raddr_flat,
    output logic [NUM_BRAMS-1:0]                     bram_we,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0]          bram_waddr_flat,
    output logic [NUM_BRAMS*DW-1:0]                  bram_din_flat,
    output logic [NUM_BRAMS-1:0]                     bram_re,
    output logic [NUM_BRAMS*ADDR_WIDTH-1:0]          bram_raddr_flat,
    output logic [NUM_BRAMS-1:0]                     rd_valid
`ifdef MODE_VIOLATION_CNT_EN
    ,
    output logic [15:0]                              viol_cnt
`endif
);

    localparam int BUS_A = NUM_BRAMS * ADDR_WIDTH;
    localparam int BUS_D = NUM_BRAMS * DW;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                 state;
    logic [MODE_W-1:0]      pend_mode;
    logic [CNT_W-1:0]       drain_cnt;

    logic [NUM_BRAMS-1:0]   sel_we;
    logic [NUM_BRAMS-1:0]   sel_re;
    logic [BUS_A-1:0]       sel_waddr;
    logic [BUS_A-1:0]       sel_raddr;
    logic [BUS_D-1:0]       sel_din;

    logic [NUM_BRAMS-1:0]   rd_pipe [READ_LATENCY];

    // Pick the bundle that belongs to the current mode.
    always_comb begin
        sel_we    = '0;
        sel_re    = '0;
        sel_waddr = '0;
        sel_raddr = '0;
        sel_din   = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (cur_mode == MODE_W'(k)) begin
                sel_we    = m_we_flat[k*NUM_BRAMS +: NUM_BRAMS];
                sel_re    = m_re_flat[k*NUM_BRAMS +: NUM_BRAMS];
                sel_waddr = m_waddr_flat[k*BUS_A +: BUS_A];
                sel_raddr = m_raddr_flat[k*BUS_A +: BUS_A];
                sel_din   = m_din_flat[k*BUS_D +: BUS_D];
            end
        end
    end

    // Mode FSM plus the registered BRAM port. Addresses and data hold their
    // last values outside ACTIVE; only the enables are forced low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_ACTIVE;
            cur_mode        <= MODE_W'(RESET_MODE);
            pend_mode       <= '0;
            drain_cnt       <= '0;
            mode_ack        <= 1'b0;
            mode_err        <= 1'b0;
            bram_we         <= '0;
            bram_re         <= '0;
            bram_waddr_flat <= '0;
            bram_raddr_flat <= '0;
            bram_din_flat   <= '0;
        end else begin
            mode_ack <= 1'b0;
            mode_err <= 1'b0;
            case (state)
                ST_ACTIVE: begin
                    bram_we         <= sel_we;
                    bram_re         <= sel_re;
                    bram_waddr_flat <= sel_waddr;
                    bram_raddr_flat <= sel_raddr;
                    bram_din_flat   <= sel_din;
                    if (mode_req_valid) begin
                        if ({1'b0, mode_req_id} >= (MODE_W+1)'(NUM_MODES)) begin
                            mode_err <= 1'b1;
                        end else if (mode_req_id == cur_mode) begin
                            mode_ack <= 1'b1;
                        end else begin
                            pend_mode <= mode_req_id;
                            drain_cnt <= CNT_W'(READ_LATENCY - 1);
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    bram_we <= '0;
                    bram_re <= '0;
                    if (drain_cnt == '0) begin
                        if (rd_valid == '0)
                            state <= ST_SWITCH;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_SWITCH: begin
                    bram_we  <= '0;
                    bram_re  <= '0;
                    cur_mode <= pend_mode;
                    mode_ack <= 1'b1;
                    state    <= ST_ACTIVE;
                end
                default: state <= ST_ACTIVE;
            endcase
        end
    end

    // Per-bank read-valid delay line: bram_re delayed READ_LATENCY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++)
                rd_pipe[i] <= '0;
        end else begin
            rd_pipe[0] <= bram_re;
            for (int i = 1; i < READ_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rd_valid       = rd_pipe[READ_LATENCY-1];
    assign mode_req_ready = (state == ST_ACTIVE);
    assign mode_busy      = (state != ST_ACTIVE);

`ifdef MODE_VIOLATION_CNT_EN
    logic viol_hit;

    // Flag any enable from a mode that does not currently own the array.
    always_comb begin
        viol_hit = 1'b0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if ((state != ST_ACTIVE || cur_mode != MODE_W'(k)) &&
                ((|m_we_flat[k*NUM_BRAMS +: NUM_BRAMS]) ||
                 (|m_re_flat[k*NUM_BRAMS +: NUM_BRAMS])))
                viol_hit = 1'b1;
        end
    end

    // Saturating violation counter, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            viol_cnt <= '0;
        else if (viol_hit && viol_cnt != 16'hFFFF)
            viol_cnt <= viol_cnt + 16'd1;
    end
`endif

endmodule
